// File: rtl/stroke_pkg.sv
// -----------------------------------------------------------------------------
// stroke_pkg
//  Shared types for the erg stroke pipeline (phase timer, stroke-rate block).
//  Ports: none (package).
//  Build option: none.
// -----------------------------------------------------------------------------
package stroke_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_DRIVE = 2'd1,
    PH_RECOV = 2'd2
  } phase_e;

endpackage

// File: rtl/stroke_phase_timer_if.sv
// -----------------------------------------------------------------------------
// stroke_phase_timer_if
//  Bundles the start pulses from the sensor edge detector and the phase/length
//  results going to the stroke-rate/power datapath.
//  Modports:
//    master : drives start_drive/start_recovery, observes timer results
//    slave  : the phase timer itself
//  Build option: STROKE_COUNT_EN adds the stroke_count signal.
// -----------------------------------------------------------------------------
interface stroke_phase_timer_if #(
  parameter int CNT_W = 32,
  parameter int SCW   = 16
);
  import stroke_pkg::*;

  logic             start_drive;
  logic             start_recovery;
  phase_e           phase;
  logic [CNT_W-1:0] drive_count;
  logic [CNT_W-1:0] recovery_count;
  logic [CNT_W-1:0] drive_len;
  logic [CNT_W-1:0] recovery_len;
  logic             stroke_valid;
  logic             timeout;
  logic             protocol_err;
`ifdef STROKE_COUNT_EN
  logic [SCW-1:0]   stroke_count;
`endif

  modport master (
    output start_drive, start_recovery,
    input  phase, drive_count, recovery_count, drive_len, recovery_len,
    input  stroke_valid, timeout, protocol_err
`ifdef STROKE_COUNT_EN
    , input stroke_count
`endif
  );

  modport slave (
    input  start_drive, start_recovery,
    output phase, drive_count, recovery_count, drive_len, recovery_len,
    output stroke_valid, timeout, protocol_err
`ifdef STROKE_COUNT_EN
    , output stroke_count
`endif
  );

endinterface

// File: rtl/stroke_phase_timer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//  Up-counter that sticks at all-ones instead of wrapping.
//  Ports:
//    clk, reset  clock / synchronous active-high reset
//    clear       count <= 0 (highest priority after reset)
//    load_one    count <= 1
//    inc         count <= count + 1, saturating
//    count       registered count value
//  Build option: none.
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load_one,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load_one) begin
      count_d = W'(1);
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stroke_phase_timer.sv
// -----------------------------------------------------------------------------
// stroke_phase_timer
//  Times the drive and recovery phases of each stroke in clk cycles, latches
//  the lengths of every completed stroke, forces IDLE when a phase is
//  abandoned, and flags simultaneous start pulses.
//  Ports:
//    clk    system clock, rising edge
//    reset  synchronous, active-high
//    bus    stroke_phase_timer_if.slave (start pulses in, phase/counts/lengths,
//           stroke_valid, timeout, protocol_err out)
//  Parameters: CNT_W counter width, TIMEOUT phase limit (0 = off), SCW
//  stroke_count width.
//  Build option: STROKE_COUNT_EN enables the wrapping stroke_count output.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  PH_IDLE  | no stroke in progress; waiting for start_drive
//  PH_DRIVE | drive phase; drive counter running
//  PH_RECOV | recovery phase; recovery counter running
// -----------------------------------------------------------------------------
module stroke_phase_timer
  import stroke_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100_000_000,
  parameter int          SCW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stroke_phase_timer_if.slave   bus
);

  localparam logic [CNT_W-1:0] TO_CMP = CNT_W'(TIMEOUT);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] drive_len_q, drive_len_d;
  logic [CNT_W-1:0] recov_len_q, recov_len_d;
  logic             stroke_valid_q, stroke_valid_d;
  logic             timeout_q, timeout_d;
  logic             protocol_err_q, protocol_err_d;

  logic [CNT_W-1:0] drive_cnt, recov_cnt, active_cnt;
  logic             d_clr, d_load, d_inc;
  logic             r_clr, r_load, r_inc;
  logic             both_start, go_drive, go_recov, at_timeout;

`ifdef STROKE_COUNT_EN
  logic [SCW-1:0]   stroke_count_q, stroke_count_d;
`endif

  sat_counter #(.W(CNT_W)) u_drive_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (d_clr),
    .load_one (d_load),
    .inc      (d_inc),
    .count    (drive_cnt)
  );

  sat_counter #(.W(CNT_W)) u_recov_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_clr),
    .load_one (r_load),
    .inc      (r_inc),
    .count    (recov_cnt)
  );

  always_comb begin
    // Simultaneous starts cancel each other out; only the error flag reacts.
    both_start = bus.start_drive & bus.start_recovery;
    go_drive   = bus.start_drive & ~bus.start_recovery;
    go_recov   = bus.start_recovery & ~bus.start_drive;
    active_cnt = (state_q == PH_DRIVE) ? drive_cnt : recov_cnt;
    at_timeout = (TIMEOUT != 0) && (active_cnt == TO_CMP);

    state_d        = state_q;
    drive_len_d    = drive_len_q;
    recov_len_d    = recov_len_q;
    stroke_valid_d = 1'b0;
    timeout_d      = 1'b0;
    protocol_err_d = protocol_err_q | both_start;
    d_clr  = 1'b0;
    d_load = 1'b0;
    d_inc  = 1'b0;
    r_clr  = 1'b0;
    r_load = 1'b0;
    r_inc  = 1'b0;
`ifdef STROKE_COUNT_EN
    stroke_count_d = stroke_count_q;
`endif

    case (state_q)
      PH_IDLE: begin
        if (go_drive) begin
          state_d = PH_DRIVE;
          d_load  = 1'b1;
        end
      end
      PH_DRIVE: begin
        // A legal transition in the timeout cycle takes priority.
        if (go_recov) begin
          state_d     = PH_RECOV;
          drive_len_d = drive_cnt;
          d_clr       = 1'b1;
          r_load      = 1'b1;
        end else if (at_timeout) begin
          state_d   = PH_IDLE;
          d_clr     = 1'b1;
          r_clr     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          d_inc = 1'b1;
        end
      end
      PH_RECOV: begin
        if (go_drive) begin
          state_d        = PH_DRIVE;
          recov_len_d    = recov_cnt;
          r_clr          = 1'b1;
          d_load         = 1'b1;
          stroke_valid_d = 1'b1;
`ifdef STROKE_COUNT_EN
          stroke_count_d = stroke_count_q + SCW'(1);
`endif
        end else if (at_timeout) begin
          state_d   = PH_IDLE;
          d_clr     = 1'b1;
          r_clr     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          r_inc = 1'b1;
        end
      end
      default: begin
        state_d = PH_IDLE;
        d_clr   = 1'b1;
        r_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PH_IDLE;
      drive_len_q    <= '0;
      recov_len_q    <= '0;
      stroke_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      protocol_err_q <= 1'b0;
`ifdef STROKE_COUNT_EN
      stroke_count_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      drive_len_q    <= drive_len_d;
      recov_len_q    <= recov_len_d;
      stroke_valid_q <= stroke_valid_d;
      timeout_q      <= timeout_d;
      protocol_err_q <= protocol_err_d;
`ifdef STROKE_COUNT_EN
      stroke_count_q <= stroke_count_d;
`endif
    end
  end

  assign bus.phase          = state_q;
  assign bus.drive_count    = drive_cnt;
  assign bus.recovery_count = recov_cnt;
  assign bus.drive_len      = drive_len_q;
  assign bus.recovery_len   = recov_len_q;
  assign bus.stroke_valid   = stroke_valid_q;
  assign bus.timeout        = timeout_q;
  assign bus.protocol_err   = protocol_err_q;
`ifdef STROKE_COUNT_EN
  assign bus.stroke_count   = stroke_count_q;
`endif

endmodule

// File: tb/tb_stroke_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_stroke_phase_timer
//  Two timers side by side on the same stimulus: dut_a with TIMEOUT=50 and
//  dut_b with TIMEOUT=0 (saturation case), both CNT_W=8.  The reference model
//  tracks, per instance, the phase and the cycle at which it was entered, and
//  derives counts and lengths from elapsed time.
// -----------------------------------------------------------------------------
module tb_stroke_phase_timer;
  import stroke_pkg::*;

  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stroke_phase_timer_if #(.CNT_W(8), .SCW(16)) bus_a ();
  stroke_phase_timer_if #(.CNT_W(8), .SCW(16)) bus_b ();

  stroke_phase_timer #(.CNT_W(8), .TIMEOUT(50), .SCW(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  stroke_phase_timer #(.CNT_W(8), .TIMEOUT(0), .SCW(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int tmo [2] = '{50, 0};
  int k = 0;
  int m_ph [2], m_e [2], m_dlen [2], m_rlen [2], m_sc [2];
  bit m_sv [2], m_to [2], m_perr [2];

  typedef struct {
    bit sd, sr, rs;
    int ph, dc, rc, dl, rl;
    bit sv, to, pe;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic int elapsed(input int i, input int extra);
    int v;
    v = k - m_e[i] + extra;
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_edge(input bit sd, input bit sr, input bit rs);
    for (int i = 0; i < 2; i++) begin
      int prev;
      bit vd, vr;
      prev = (m_ph[i] != 0) ? elapsed(i, 0) : 0;
      m_sv[i] = 0;
      m_to[i] = 0;
      vd = sd && !sr;
      vr = sr && !sd;
      if (rs) begin
        m_ph[i] = 0; m_dlen[i] = 0; m_rlen[i] = 0; m_perr[i] = 0; m_sc[i] = 0;
      end else begin
        if (sd && sr) m_perr[i] = 1;
        case (m_ph[i])
          0: if (vd) begin m_ph[i] = 1; m_e[i] = k; end
          1: begin
            if (vr) begin
              m_dlen[i] = prev; m_ph[i] = 2; m_e[i] = k;
            end else if (tmo[i] != 0 && prev == tmo[i]) begin
              m_ph[i] = 0; m_to[i] = 1;
            end
          end
          default: begin
            if (vd) begin
              m_rlen[i] = prev; m_ph[i] = 1; m_e[i] = k; m_sv[i] = 1;
              m_sc[i] = (m_sc[i] + 1) % 65536;
            end else if (tmo[i] != 0 && prev == tmo[i]) begin
              m_ph[i] = 0; m_to[i] = 1;
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_inst(input int i, input int ph, input int dc, input int rc,
                            input int dl, input int rl, input int sv, input int to,
                            input int pe);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, "_phase"},  ph, m_ph[i]);
    chk({p, "_dcount"}, dc, (m_ph[i] == 1) ? elapsed(i, 1) : 0);
    chk({p, "_rcount"}, rc, (m_ph[i] == 2) ? elapsed(i, 1) : 0);
    chk({p, "_dlen"},   dl, m_dlen[i]);
    chk({p, "_rlen"},   rl, m_rlen[i]);
    chk({p, "_valid"},  sv, int'(m_sv[i]));
    chk({p, "_tmo"},    to, int'(m_to[i]));
    chk({p, "_perr"},   pe, int'(m_perr[i]));
  endtask

  task automatic step(input bit sd, input bit sr, input bit rs);
    bus_a.start_drive = sd; bus_a.start_recovery = sr;
    bus_b.start_drive = sd; bus_b.start_recovery = sr;
    reset = rs;
    @(posedge clk);
    k++;
    model_edge(sd, sr, rs);
    #1;
    check_inst(0, int'(bus_a.phase), int'(bus_a.drive_count), int'(bus_a.recovery_count),
               int'(bus_a.drive_len), int'(bus_a.recovery_len), int'(bus_a.stroke_valid),
               int'(bus_a.timeout), int'(bus_a.protocol_err));
    check_inst(1, int'(bus_b.phase), int'(bus_b.drive_count), int'(bus_b.recovery_count),
               int'(bus_b.drive_len), int'(bus_b.recovery_len), int'(bus_b.stroke_valid),
               int'(bus_b.timeout), int'(bus_b.protocol_err));
`ifdef STROKE_COUNT_EN
    chk("a_scount", int'(bus_a.stroke_count), m_sc[0]);
    chk("b_scount", int'(bus_b.stroke_count), m_sc[1]);
`endif
  endtask

  initial begin
    int sv_cnt, sv_at, last_dc, hit, quiet;

    //            sd sr rs  ph dc rc dl rl sv to pe
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1, 5, 0, 0, 0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1, 5, 0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2, 0, 2, 5, 0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1, 1, 0, 5, 2, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1, 2, 0, 5, 2, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_e[i] = 0; m_dlen[i] = 0; m_rlen[i] = 0; m_sc[i] = 0;
      m_sv[i] = 0; m_to[i] = 0; m_perr[i] = 0;
    end
    bus_a.start_drive = 0; bus_a.start_recovery = 0;
    bus_b.start_drive = 0; bus_b.start_recovery = 0;
    reset = 1;
    @(negedge clk);

    // fixed vectors: reset, ignored pulses, simultaneous starts, one stroke
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].sd, tbl[i].sr, tbl[i].rs);
      chk($sformatf("tbl%0d_phase", i), int'(bus_a.phase),          tbl[i].ph);
      chk($sformatf("tbl%0d_dcnt", i),  int'(bus_a.drive_count),    tbl[i].dc);
      chk($sformatf("tbl%0d_rcnt", i),  int'(bus_a.recovery_count), tbl[i].rc);
      chk($sformatf("tbl%0d_dlen", i),  int'(bus_a.drive_len),      tbl[i].dl);
      chk($sformatf("tbl%0d_rlen", i),  int'(bus_a.recovery_len),   tbl[i].rl);
      chk($sformatf("tbl%0d_valid", i), int'(bus_a.stroke_valid),   int'(tbl[i].sv));
      chk($sformatf("tbl%0d_tmo", i),   int'(bus_a.timeout),        int'(tbl[i].to));
      chk($sformatf("tbl%0d_perr", i),  int'(bus_a.protocol_err),   int'(tbl[i].pe));
    end

    // stroke with drive 10, recovery 20
    step(0, 0, 1);
    sv_cnt = 0; sv_at = -1;
    for (int c = 0; c <= 35; c++) begin
      step(c == 0 || c == 30, c == 10, 0);
      if (bus_a.stroke_valid) begin sv_cnt++; sv_at = c; end
    end
    chk("s1_valid_count", sv_cnt, 1);
    chk("s1_valid_edge", sv_at, 30);
    chk("s1_dlen", int'(bus_a.drive_len), 10);
    chk("s1_rlen", int'(bus_a.recovery_len), 20);
    chk("s1_phase", int'(bus_a.phase), int'(PH_DRIVE));

    // abandoned drive: dut_a times out at count 50
    hit = 0; last_dc = -1;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (!bus_a.timeout) last_dc = int'(bus_a.drive_count);
      step(0, 0, 0);
      if (bus_a.timeout) hit = 1;
    end
    chk("s2_timeout_seen", hit, 1);
    chk("s2_dcount_at_tmo", last_dc, 50);
    chk("s2_phase", int'(bus_a.phase), int'(PH_IDLE));
    chk("s2_dcount", int'(bus_a.drive_count), 0);
    chk("s2_dlen", int'(bus_a.drive_len), 10);
    chk("s2_rlen", int'(bus_a.recovery_len), 20);
    step(0, 0, 0);
    chk("s2_tmo_pulse", int'(bus_a.timeout), 0);

    // dut_b: 300-cycle drive saturates at 255
    step(0, 0, 1);
    step(1, 0, 0);
    for (int c = 0; c < 300; c++) step(0, 0, 0);
    chk("s3_dcount_sat", int'(bus_b.drive_count), 255);
    step(0, 1, 0);
    chk("s3_dlen_sat", int'(bus_b.drive_len), 255);
    chk("s3_phase", int'(bus_b.phase), int'(PH_RECOV));

    // reset mid-recovery with protocol_err set
    step(0, 0, 1);
    step(1, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("s6_perr_before", int'(bus_a.protocol_err), 1);
    step(0, 0, 1);
    chk("s6_phase", int'(bus_a.phase), 0);
    chk("s6_rcount", int'(bus_a.recovery_count), 0);
    chk("s6_dlen", int'(bus_a.drive_len), 0);
    chk("s6_perr", int'(bus_a.protocol_err), 0);

`ifdef STROKE_COUNT_EN
    for (int c = 0; c < 7; c++) begin
      step(c % 2 == 0, c % 2 == 1, 0);
      step(0, 0, 0);
    end
    chk("sc_three", int'(bus_a.stroke_count), 3);
`endif

    // randomized traffic with occasional quiet spells to reach the timeout
    step(0, 0, 1);
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      bit sd, sr, rs;
      if (c % 250 == 0) quiet = ($urandom_range(0, 2) == 0);
      if (quiet) begin
        sd = ($urandom_range(0, 79) == 0);
        sr = ($urandom_range(0, 79) == 0);
      end else begin
        sd = ($urandom_range(0, 9) == 0);
        sr = ($urandom_range(0, 9) == 0);
      end
      rs = ($urandom_range(0, 599) == 0);
      step(sd, sr, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
